// File: rtl/clken_gen_pkg.sv
// Shared definitions for the clock-enable generator: FSM state encoding,
// synchroniser depth, lock-filter length and a select-width helper.
package clken_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int SYNC_STAGES     = 2;
    localparam int LOCK_FILTER_LEN = 4;

    // Width of a channel-select field; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clken_gen_sync2.sv
// Two-flop synchroniser for a single asynchronous status bit.
// Resets to 0 so a lock indication is never seen before real sampling.
module clken_gen_sync2
    import clken_gen_pkg::*;
(
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator built from phase accumulators.
// Pulses are produced only after the upstream PLL has been locked for a
// settle period. Optional macro CLKEN_GEN_LOCK_FILTER_EN makes the RUN
// state tolerate lock drops shorter than LOCK_FILTER_LEN cycles.
module clken_gen
    import clken_gen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic                          pll_locked,
    input  logic                          inc_wr,
    input  logic [sel_width(NUM_CH)-1:0]  inc_ch,
    input  logic [ACC_W-1:0]              inc_data,
    output logic [NUM_CH-1:0]             ce,
    output logic                          locked
);

    localparam int                CH_W      = sel_width(NUM_CH);
    localparam int                CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
    // Divide-by-2 increment after reset.
    localparam logic [ACC_W-1:0]  INC_RESET = {1'b1, {(ACC_W-1){1'b0}}};

    logic             w_lk_s;
    logic             w_lock_lost;
    logic             w_accum_en;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    clken_gen_sync2 u_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (pll_locked),
        .q      (w_lk_s)
    );

`ifdef CLKEN_GEN_LOCK_FILTER_EN
    localparam logic [1:0] LOW_LAST = 2'(LOCK_FILTER_LEN - 1);
    logic [1:0] r_low_cnt;

    // Count consecutive low lock samples while running; any high sample clears.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_low_cnt <= '0;
        end else if ((r_state != RUN) || w_lk_s) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt != LOW_LAST) begin
            r_low_cnt <= r_low_cnt + 2'd1;
        end
    end

    assign w_lock_lost = !w_lk_s && (r_low_cnt == LOW_LAST);
`else
    assign w_lock_lost = !w_lk_s;
`endif

    // State and settle-counter registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; the counter only advances while settling.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            IDLE: begin
                if (w_lk_s) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!w_lk_s) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (w_lock_lost) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign locked = (r_state == RUN);

    // Accumulate only while staying in RUN: the entry edge leaves every
    // accumulator at zero (phase alignment) and the exit edge clears ce so
    // no pulse is visible outside RUN.
    assign w_accum_en = (r_state == RUN) && (w_state_next == RUN);

    logic [ACC_W-1:0] r_inc [NUM_CH];
    logic [ACC_W-1:0] r_acc [NUM_CH];
    logic             r_ce  [NUM_CH];
    logic [ACC_W:0]   w_sum [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
            // Increment register; selects outside 0..NUM_CH-1 match no channel.
            always_ff @(posedge refclk or posedge rst) begin
                if (rst) begin
                    r_inc[gi] <= INC_RESET;
                end else if (inc_wr && (inc_ch == CH_W'(gi))) begin
                    r_inc[gi] <= inc_data;
                end
            end

            assign w_sum[gi] = {1'b0, r_acc[gi]} + {1'b0, r_inc[gi]};

            // Phase accumulator; the carry out becomes the enable pulse.
            always_ff @(posedge refclk or posedge rst) begin
                if (rst) begin
                    r_acc[gi] <= '0;
                    r_ce[gi]  <= 1'b0;
                end else if (w_accum_en) begin
                    r_acc[gi] <= w_sum[gi][ACC_W-1:0];
                    r_ce[gi]  <= w_sum[gi][ACC_W];
                end else begin
                    r_acc[gi] <= '0;
                    r_ce[gi]  <= 1'b0;
                end
            end

            assign ce[gi] = r_ce[gi];
        end
    endgenerate

endmodule
